// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: controller states,
// opcodes and datapath mux/ALU encodings.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } ctrl_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instrdec.sv
// Immediate-format decode: selects the ImmExt layout from the opcode.
module instrdec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] immsrc
);

    // Opcode to immediate format; I-type layout is the default.
    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle RV32I core: sequences each
// instruction and drives datapath enables, mux selects and aluop.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       illegal
);

    ctrl_state_t state_q, state_d;
    logic        pcupdate;
    logic        branch;

    instrdec u_instrdec (
        .op     (op),
        .immsrc (immsrc)
    );

    // State register; reset forces FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; unreachable encodings fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        illegal = 1'b0;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // State-decoded datapath controls; anything not set stays 0.
    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
            end
            MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regwrite = 1'b1;
            end
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            BEQ: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);

endmodule
